// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - irrigation cycle sequencer with tank supply hysteresis
//
// Sequences one irrigation cycle: wait for demand, latch sprinkler or dripper mode,
// run for a timed period, rest, then accept a new cycle. Conflicting level-sensor
// combinations trap the block in FAULT until the sensors read consistent for
// SETTLE_TICKS consecutive ticks. The tank supply valve opens below the mid sensor
// and closes at the high sensor.
//
// Optional feature macro: IRRIGATION_COUNT_EN adds the cycles_done counter output.
//
// Ports:
//   clock, reset           system clock, asynchronous active-high reset
//   tick                   one-cycle pulse per second
//   low/mid/high_water_level  tank level sensors (1 = water above sensor)
//   earth_humidity         1 = soil wet, no irrigation demand
//   air_humidity           1 = air humid
//   low_temperature        1 = temperature low
//   splinker_bomb          sprinkler pump on
//   dripper_valvule        dripper valve open
//   supply_valvule         tank supply valve open
//   alarm                  FAULT or tank below low sensor
//   state                  00 IDLE, 01 RUN, 10 REST, 11 FAULT
//   remaining              seconds left in RUN/REST, 0 otherwise
//   cycles_done            (IRRIGATION_COUNT_EN only) completed full runs, saturating
module irrigation_scheduler #(
  parameter int TIMER_W       = 12,
  parameter int SPLINKER_SECS = 600,
  parameter int DRIPPER_SECS  = 1800,
  parameter int REST_SECS     = 300,
  parameter int SETTLE_TICKS  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               low_water_level,
  input  logic               mid_water_level,
  input  logic               high_water_level,
  input  logic               earth_humidity,
  input  logic               air_humidity,
  input  logic               low_temperature,
  output logic               splinker_bomb,
  output logic               dripper_valvule,
  output logic               supply_valvule,
  output logic               alarm,
  output logic [1:0]         state,
  output logic [TIMER_W-1:0] remaining
`ifdef IRRIGATION_COUNT_EN
  ,
  output logic [7:0]         cycles_done
`endif
);

  localparam int SETTLE_W = $clog2(SETTLE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_REST  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   remaining_q, remaining_d;
  logic                 mode_splinker_q, mode_splinker_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 splinker_q, splinker_d;
  logic                 dripper_q, dripper_d;
  logic                 supply_q, supply_d;
  logic                 alarm_q, alarm_d;
`ifdef IRRIGATION_COUNT_EN
  logic [7:0]           cycles_q, cycles_d;
`endif

  logic                 conflict;
  logic [SETTLE_W-1:0]  settle_inc;

  // A higher sensor wet while a lower one is dry cannot happen physically.
  assign conflict   = (mid_water_level & ~low_water_level) | (high_water_level & ~mid_water_level);
  assign settle_inc = settle_q + SETTLE_W'(1);

  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    mode_splinker_d = mode_splinker_q;
    settle_d        = settle_q;
`ifdef IRRIGATION_COUNT_EN
    cycles_d        = cycles_q;
`endif

    if (conflict) begin
      state_d     = ST_FAULT;
      remaining_d = '0;
      settle_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!earth_humidity && low_water_level) begin
            state_d         = ST_RUN;
            mode_splinker_d = ~air_humidity & ~low_temperature & mid_water_level;
            remaining_d     = (~air_humidity & ~low_temperature & mid_water_level)
                              ? TIMER_W'(SPLINKER_SECS) : TIMER_W'(DRIPPER_SECS);
          end
        end
        ST_RUN: begin
          // Abort takes precedence over a coincident tick: no decrement, no count.
          if (earth_humidity || !low_water_level) begin
            state_d     = ST_REST;
            remaining_d = TIMER_W'(REST_SECS);
          end else if (tick) begin
            if (remaining_q == TIMER_W'(1)) begin
              state_d     = ST_REST;
              remaining_d = TIMER_W'(REST_SECS);
`ifdef IRRIGATION_COUNT_EN
              if (cycles_q != 8'hFF) cycles_d = cycles_q + 8'd1;
`endif
            end else begin
              remaining_d = remaining_q - TIMER_W'(1);
            end
          end
        end
        ST_REST: begin
          if (tick) begin
            if (remaining_q == TIMER_W'(1)) begin
              state_d     = ST_IDLE;
              remaining_d = '0;
            end else begin
              remaining_d = remaining_q - TIMER_W'(1);
            end
          end
        end
        ST_FAULT: begin
          remaining_d = '0;
          if (tick) begin
            if (settle_inc == SETTLE_W'(SETTLE_TICKS)) begin
              state_d  = ST_IDLE;
              settle_d = '0;
            end else begin
              settle_d = settle_inc;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are derived from the next state so they line up with state/remaining.
    splinker_d = (state_d == ST_RUN) &  mode_splinker_d;
    dripper_d  = (state_d == ST_RUN) & ~mode_splinker_d;
    alarm_d    = (state_d == ST_FAULT) | ~low_water_level;

    // Hysteresis between mid (open) and high (close); the two conditions are
    // mutually exclusive without a conflict. Leaving FAULT starts from closed.
    if (state_d == ST_FAULT)      supply_d = 1'b0;
    else if (!mid_water_level)    supply_d = 1'b1;
    else if (high_water_level)    supply_d = 1'b0;
    else                          supply_d = supply_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      remaining_q     <= '0;
      mode_splinker_q <= 1'b0;
      settle_q        <= '0;
      splinker_q      <= 1'b0;
      dripper_q       <= 1'b0;
      supply_q        <= 1'b0;
      alarm_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      mode_splinker_q <= mode_splinker_d;
      settle_q        <= settle_d;
      splinker_q      <= splinker_d;
      dripper_q       <= dripper_d;
      supply_q        <= supply_d;
      alarm_q         <= alarm_d;
    end
  end

`ifdef IRRIGATION_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycles_q <= 8'd0;
    else       cycles_q <= cycles_d;
  end

  assign cycles_done = cycles_q;
`endif

  assign splinker_bomb   = splinker_q;
  assign dripper_valvule = dripper_q;
  assign supply_valvule  = supply_q;
  assign alarm           = alarm_q;
  assign state           = state_q;
  assign remaining       = remaining_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb/tb_irrigation_scheduler.sv - directed self-checking bench for irrigation_scheduler
module tb_irrigation_scheduler;

  localparam int TIMER_W = 12;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               tick = 1'b0;
  logic               low_water_level = 1'b1;
  logic               mid_water_level = 1'b1;
  logic               high_water_level = 1'b0;
  logic               earth_humidity = 1'b1;
  logic               air_humidity = 1'b1;
  logic               low_temperature = 1'b0;
  logic               splinker_bomb;
  logic               dripper_valvule;
  logic               supply_valvule;
  logic               alarm;
  logic [1:0]         state;
  logic [TIMER_W-1:0] remaining;
`ifdef IRRIGATION_COUNT_EN
  logic [7:0]         cycles_done;
`endif

  int checks = 0;
  int errors = 0;

  irrigation_scheduler #(
    .TIMER_W(TIMER_W), .SPLINKER_SECS(600), .DRIPPER_SECS(1800),
    .REST_SECS(300), .SETTLE_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .low_water_level(low_water_level), .mid_water_level(mid_water_level),
    .high_water_level(high_water_level), .earth_humidity(earth_humidity),
    .air_humidity(air_humidity), .low_temperature(low_temperature),
    .splinker_bomb(splinker_bomb), .dripper_valvule(dripper_valvule),
    .supply_valvule(supply_valvule), .alarm(alarm), .state(state),
    .remaining(remaining)
`ifdef IRRIGATION_COUNT_EN
    , .cycles_done(cycles_done)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic set_levels(input logic l, input logic m, input logic h);
    low_water_level  = l;
    mid_water_level  = m;
    high_water_level = h;
  endtask

  initial begin
    step();
    step();
    check("rst_state", state, 0);
    check("rst_remaining", remaining, 0);
    check("rst_splinker", splinker_bomb, 0);
    check("rst_dripper", dripper_valvule, 0);
    check("rst_supply", supply_valvule, 0);
    check("rst_alarm", alarm, 0);
`ifdef IRRIGATION_COUNT_EN
    check("rst_cycles", cycles_done, 0);
`endif
    reset = 1'b0;
    step();
    check("idle_wet_state", state, 0);
    check("idle_supply_hold", supply_valvule, 0);

    // Dripper full cycle: humid air forces dripper mode.
    earth_humidity = 1'b0;
    air_humidity   = 1'b1;
    step();
    check("drip_state", state, 1);
    check("drip_valve", dripper_valvule, 1);
    check("drip_splinker", splinker_bomb, 0);
    check("drip_remaining", remaining, 1800);
    ticks(1799);
    check("drip_rem_1", remaining, 1);
    check("drip_still_run", state, 1);
    ticks(1);
    check("drip_rest_state", state, 2);
    check("drip_rest_rem", remaining, 300);
    check("drip_rest_valve", dripper_valvule, 0);
    ticks(299);
    check("rest_ignores_demand", state, 2);
    check("rest_rem_1", remaining, 1);
    earth_humidity = 1'b1;
    ticks(1);
    check("rest_to_idle", state, 0);
    check("idle_rem", remaining, 0);
`ifdef IRRIGATION_COUNT_EN
    check("cycles_after_full", cycles_done, 1);
`endif

    // Splinker cycle with mid-run weather change and soil-wet abort at 42.
    air_humidity    = 1'b0;
    low_temperature = 1'b0;
    earth_humidity  = 1'b0;
    step();
    check("spl_state", state, 1);
    check("spl_pump", splinker_bomb, 1);
    check("spl_dripper", dripper_valvule, 0);
    check("spl_remaining", remaining, 600);
    air_humidity = 1'b1;
    ticks(1);
    check("spl_mode_held", splinker_bomb, 1);
    check("spl_mode_held_drip", dripper_valvule, 0);
    check("spl_rem_599", remaining, 599);
    ticks(557);
    check("spl_rem_42", remaining, 42);
    earth_humidity = 1'b1;
    ticks(1);
    check("abort_state", state, 2);
    check("abort_rem", remaining, 300);
    check("abort_pump", splinker_bomb, 0);
    check("abort_drip", dripper_valvule, 0);
`ifdef IRRIGATION_COUNT_EN
    check("abort_cycles", cycles_done, 1);
`endif
    ticks(300);
    check("abort_rest_done", state, 0);

    // Conflict in RUN -> FAULT, then settling with an interrupting conflict tick.
    earth_humidity = 1'b0;
    step();
    check("fault_pre_run", state, 1);
    earth_humidity = 1'b1;
    set_levels(1'b1, 1'b0, 1'b1);
    step();
    check("fault_state", state, 3);
    check("fault_alarm", alarm, 1);
    check("fault_rem", remaining, 0);
    check("fault_drip", dripper_valvule, 0);
    check("fault_supply", supply_valvule, 0);
    set_levels(1'b1, 1'b1, 1'b0);
    ticks(2);
    check("fault_settle2", state, 3);
    set_levels(1'b1, 1'b0, 1'b1);
    ticks(1);
    check("fault_conflict_tick", state, 3);
    set_levels(1'b1, 1'b1, 1'b0);
    ticks(2);
    check("fault_settle_again2", state, 3);
    ticks(1);
    check("fault_exit", state, 0);
    check("fault_exit_alarm", alarm, 0);
    check("fault_exit_supply", supply_valvule, 0);

    // Supply hysteresis.
    set_levels(1'b1, 1'b0, 1'b0);
    step();
    check("supply_open", supply_valvule, 1);
    set_levels(1'b1, 1'b1, 1'b0);
    step();
    check("supply_hold_open", supply_valvule, 1);
    set_levels(1'b1, 1'b1, 1'b1);
    step();
    check("supply_close", supply_valvule, 0);
    set_levels(1'b1, 1'b1, 1'b0);
    step();
    check("supply_hold_closed", supply_valvule, 0);
    set_levels(1'b0, 1'b0, 1'b0);
    step();
    check("low_alarm", alarm, 1);
    check("low_supply", supply_valvule, 1);
    check("low_state", state, 0);

    // Asynchronous reset in the middle of a run.
    set_levels(1'b1, 1'b1, 1'b0);
    earth_humidity = 1'b0;
    step();
    check("arst_pre_run", state, 1);
    check("arst_pre_supply", supply_valvule, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_rem", remaining, 0);
    check("arst_drip", dripper_valvule, 0);
    check("arst_supply", supply_valvule, 0);
    check("arst_alarm", alarm, 0);
    reset = 1'b0;
    earth_humidity = 1'b1;
    step();
    check("post_arst_idle", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
